axi_burst_reader: RTL and testbench
===================================

# axi_burst_reader

Parametrised AXI4 read master that turns a single (address, beat-count) command into a sequence of INCR bursts. Bursts are split at MAX_BURST beats and at 4 KB boundaries. Returned data is buffered in an internal FIFO and presented on a ready/valid stream. It is the next-generation IFM/weight fetch path between DDR and the Functional_Unit input. Compared with the fixed 256-bit, fixed-length master, it generalises data width and burst size, handles arbitrary lengths, and applies credit-based backpressure.

## Interface
- ADDR_WIDTH, 32, AXI address width
- DATA_WIDTH, 256, AXI/stream data width; power of 2, 32..1024
- ID_WIDTH, 4, ARID width; ARID driven constant 0
- MAX_BURST, 16, max beats per burst; power of 2, 1..256
- FIFO_DEPTH, 64, data FIFO entries; power of 2, ≥ MAX_BURST
- LEN_WIDTH, 24, width of command beat count
- clk  in  1  clock
- rst  in  1  asynchronous, active-high reset
- cmd_valid  in  1  command request
- cmd_ready  out  1  command accepted when cmd_valid & cmd_ready
- cmd_addr  in  ADDR_WIDTH  start byte address; low log2(DATA_WIDTH/8) bits ignored (treated as 0)
- cmd_beats  in  LEN_WIDTH  total beats to read
- M_AXI_ARID  out  ID_WIDTH  0
- M_AXI_ARADDR  out  ADDR_WIDTH  burst address
- M_AXI_ARLEN  out  8  beats-1
- M_AXI_ARSIZE  out  3  log2(DATA_WIDTH/8)
- M_AXI_ARBURST  out  2  2'b01 (INCR)
- M_AXI_ARVALID  out  1  address valid
- M_AXI_ARREADY  in  1  address ready
- M_AXI_RDATA  in  DATA_WIDTH  read data
- M_AXI_RRESP  in  2  read response
- M_AXI_RLAST  in  1  last beat
- M_AXI_RVALID  in  1  read valid
- M_AXI_RREADY  out  1  read ready
- out_data  out  DATA_WIDTH  stream data, FIFO head
- out_valid  out  1  FIFO non-empty
- out_ready  in  1  consumer pop
- busy  out  1  state != IDLE or FIFO non-empty
- done  out  1  one-cycle pulse: all beats of the command received
- error  out  1  sticky; cleared on next command accept

## Operation
- FSM states: IDLE → (cmd accept) CALC → ADDR → DATA → CALC (beats remain) or DONE → IDLE.
- IDLE: cmd_ready=1; latch addr and remaining=cmd_beats; clear error.
- CALC: blen = min(remaining, MAX_BURST, (4096 − addr[11:0]) / (DATA_WIDTH/8)). If remaining==0, go to DONE.
- ADDR: assert ARVALID only when FIFO free entries (FIFO_DEPTH − count) ≥ blen. ARADDR and ARLEN are stable until ARREADY. On handshake, go to DATA.
- DATA: RREADY=1; space is guaranteed by the credit check. Each RVALID&RREADY pushes RDATA and increments the beat counter. On the blen-th beat: addr += blen·(DATA_WIDTH/8), remaining −= blen, go to CALC.
- Error conditions (all set error):
  - RRESP ≠ 0 on any beat.
  - RLAST=1 before the blen-th beat.
  - RLAST=0 on the blen-th beat.
- On any error condition, the data is still pushed and the burst still ends at blen beats.
- DONE: done=1 for one cycle, then IDLE. The FIFO may still hold data, and a new command may be accepted while it drains.
- FIFO: first-word-fallthrough. Simultaneous push and pop leaves count unchanged. Pop occurs only when out_valid & out_ready.
- One outstanding burst at a time.
- Address arithmetic is modulo 2^ADDR_WIDTH.

## Timing
- Reset (rst=1, async): state IDLE, FIFO empty, remaining 0. Outputs: ARVALID, RREADY, out_valid, busy, done and error all 0. cmd_ready is 0 while rst=1 and 1 in the first cycle after release.
- Command accepted at cycle T: CALC at T+1, and ARVALID can first be high at T+2.
- A beat accepted at cycle t is visible on out_data/out_valid at t+1.
- After the final beat of a burst at t: CALC at t+1; the next ARVALID can be high at t+2; done pulses at t+2 when no beats remain.
- cmd_beats=0 accepted at T: no AR issued; done pulses at T+2.
- Reset mid-burst: the burst is abandoned and the FIFO is flushed. The interconnect is reset together with this block.

## Test plan
- DATA_WIDTH=256, MAX_BURST=16, cmd 0x1000/40 beats, out_ready=1 → three ARs: 0x1000 len 15, 0x1200 len 15, 0x1400 len 7. 40 beats out in order, one done pulse, error=0.
- 4 KB crossing: cmd 0x0F80/16 → AR 0x0F80 len 3, then 0x1000 len 11.
- Backpressure: FIFO_DEPTH=64, out_ready=0, cmd 0/100 → exactly 4 ARs (64 beats), then ARVALID stays 0. It rises within 2 cycles after 16 pops.
- Zero length: cmd_beats=0 → no ARVALID; done at T+2; cmd_ready high again at T+3.
- RRESP=2 on beat 5 and an early RLAST on beat 9 of 16 → error=1, all 16 beats delivered. error clears on the next command accept.
- Reset asserted during DATA with 10 beats buffered → next cycle all outputs 0 and FIFO empty. After release, a new cmd 0x2000/4 completes normally.

Source files
------------

// File: rtl/axi_burst_reader.sv
// AXI4 read master: splits one (address, beat-count) command into INCR bursts
// capped at MAX_BURST beats and at 4 KB pages, buffering the returned data in a
// first-word-fallthrough FIFO. Address requests wait for enough FIFO credit.
module axi_burst_reader #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 256,
  parameter int ID_WIDTH   = 4,
  parameter int MAX_BURST  = 16,
  parameter int FIFO_DEPTH = 64,
  parameter int LEN_WIDTH  = 24
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [LEN_WIDTH-1:0]  cmd_beats,
  output logic [ID_WIDTH-1:0]   M_AXI_ARID,
  output logic [ADDR_WIDTH-1:0] M_AXI_ARADDR,
  output logic [7:0]            M_AXI_ARLEN,
  output logic [2:0]            M_AXI_ARSIZE,
  output logic [1:0]            M_AXI_ARBURST,
  output logic                  M_AXI_ARVALID,
  input  logic                  M_AXI_ARREADY,
  input  logic [DATA_WIDTH-1:0] M_AXI_RDATA,
  input  logic [1:0]            M_AXI_RRESP,
  input  logic                  M_AXI_RLAST,
  input  logic                  M_AXI_RVALID,
  output logic                  M_AXI_RREADY,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  busy,
  output logic                  done,
  output logic                  error
);

  localparam int BYTES = DATA_WIDTH / 8;
  localparam int SZ    = $clog2(BYTES);
  localparam int PW    = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW    = $clog2(FIFO_DEPTH) + 1;
  localparam int BW    = 9;
  localparam int KW    = (CW > BW) ? CW : BW;

  typedef enum logic [2:0] {S_IDLE, S_CALC, S_ADDR, S_DATA, S_DONE} state_e;

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [LEN_WIDTH-1:0]  rem_q, rem_d;
  logic [BW-1:0]         blen_q, blen_d;
  logic [BW-1:0]         beat_q, beat_d;
  logic                  err_q, err_d;

  logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [PW-1:0]         wptr_q, rptr_q;
  logic [CW-1:0]         cnt_q;
  logic                  push, pop, rdy_int;

  logic [12:0]           page;
  logic [BW-1:0]         cap, blen_calc;
  logic [KW-1:0]         free_k;
  logic                  cred_ok, last_beat;

  // Burst length candidates and FIFO credit
  always_comb begin
    page      = (13'd4096 - {1'b0, addr_q[11:0]}) >> SZ;
    cap       = (rem_q < LEN_WIDTH'(MAX_BURST)) ? BW'(rem_q) : BW'(MAX_BURST);
    blen_calc = ({4'b0, cap} <= page) ? cap : page[BW-1:0];
    free_k    = KW'(FIFO_DEPTH) - KW'(cnt_q);
    cred_ok   = free_k >= KW'(blen_q);
    last_beat = (beat_q == blen_q - 1'b1);
  end

  // Command/burst sequencing
  always_comb begin
    state_d       = state_q;
    addr_d        = addr_q;
    rem_d         = rem_q;
    blen_d        = blen_q;
    beat_d        = beat_q;
    err_d         = err_q;
    rdy_int       = 1'b0;
    M_AXI_ARVALID = 1'b0;
    M_AXI_RREADY  = 1'b0;
    done          = 1'b0;
    push          = 1'b0;
    case (state_q)
      S_IDLE: begin
        rdy_int = 1'b1;
        if (cmd_valid) begin
          addr_d  = cmd_addr & ~ADDR_WIDTH'(BYTES - 1);
          rem_d   = cmd_beats;
          err_d   = 1'b0;
          state_d = S_CALC;
        end
      end
      S_CALC: begin
        if (rem_q == '0) begin
          state_d = S_DONE;
        end else begin
          blen_d  = blen_calc;
          beat_d  = '0;
          state_d = S_ADDR;
        end
      end
      S_ADDR: begin
        M_AXI_ARVALID = cred_ok;
        if (cred_ok && M_AXI_ARREADY) state_d = S_DATA;
      end
      S_DATA: begin
        M_AXI_RREADY = 1'b1;
        if (M_AXI_RVALID) begin
          push = 1'b1;
          if (M_AXI_RRESP != 2'b00 || M_AXI_RLAST != last_beat) err_d = 1'b1;
          // Burst length is ours to count; RLAST only feeds the error flag.
          if (last_beat) begin
            addr_d  = addr_q + (ADDR_WIDTH'(blen_q) << SZ);
            rem_d   = rem_q - LEN_WIDTH'(blen_q);
            state_d = S_CALC;
          end else begin
            beat_d = beat_q + 1'b1;
          end
        end
      end
      S_DONE: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Control state registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      rem_q   <= '0;
      blen_q  <= '0;
      beat_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      rem_q   <= rem_d;
      blen_q  <= blen_d;
      beat_q  <= beat_d;
      err_q   <= err_d;
    end
  end

  assign pop = out_valid & out_ready;

  // FIFO pointers and occupancy
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      if (push) wptr_q <= (wptr_q == PW'(FIFO_DEPTH - 1)) ? '0 : wptr_q + 1'b1;
      if (pop)  rptr_q <= (rptr_q == PW'(FIFO_DEPTH - 1)) ? '0 : rptr_q + 1'b1;
      if (push && !pop)      cnt_q <= cnt_q + 1'b1;
      else if (pop && !push) cnt_q <= cnt_q - 1'b1;
    end
  end

  // FIFO storage
  always_ff @(posedge clk) begin
    if (push) mem[wptr_q] <= M_AXI_RDATA;
  end

  assign cmd_ready     = rdy_int & ~rst;
  assign M_AXI_ARID    = '0;
  assign M_AXI_ARADDR  = addr_q;
  assign M_AXI_ARLEN   = 8'(blen_q - 1'b1);
  assign M_AXI_ARSIZE  = 3'(SZ);
  assign M_AXI_ARBURST = 2'b01;
  assign out_data      = mem[rptr_q];
  assign out_valid     = (cnt_q != '0);
  assign busy          = (state_q != S_IDLE) || (cnt_q != '0);
  assign error         = err_q;

endmodule

// File: tb/tb_axi_burst_reader.sv
// Scoreboard bench for axi_burst_reader: expected AR requests and output
// beats are queued at command issue; one negedge monitor checks the DUT.
module tb_axi_burst_reader;

  localparam int AW = 32;
  localparam int DW = 256;
  localparam int IW = 4;
  localparam int MB = 16;
  localparam int FD = 64;
  localparam int LW = 24;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic          cmd_valid, cmd_ready;
  logic [AW-1:0] cmd_addr;
  logic [LW-1:0] cmd_beats;
  logic [IW-1:0] arid;
  logic [AW-1:0] araddr;
  logic [7:0]    arlen;
  logic [2:0]    arsize;
  logic [1:0]    arburst;
  logic          arvalid, arready;
  logic [DW-1:0] rdata;
  logic [1:0]    rresp;
  logic          rlast, rvalid, rready;
  logic [DW-1:0] out_data;
  logic          out_valid, out_ready, busy, done, error;

  always #5 clk = ~clk;

  axi_burst_reader #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .ID_WIDTH(IW),
    .MAX_BURST(MB), .FIFO_DEPTH(FD), .LEN_WIDTH(LW)
  ) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_addr(cmd_addr), .cmd_beats(cmd_beats),
    .M_AXI_ARID(arid), .M_AXI_ARADDR(araddr), .M_AXI_ARLEN(arlen), .M_AXI_ARSIZE(arsize),
    .M_AXI_ARBURST(arburst), .M_AXI_ARVALID(arvalid), .M_AXI_ARREADY(arready),
    .M_AXI_RDATA(rdata), .M_AXI_RRESP(rresp), .M_AXI_RLAST(rlast),
    .M_AXI_RVALID(rvalid), .M_AXI_RREADY(rready),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .busy(busy), .done(done), .error(error)
  );

  int tests = 0;
  int fails = 0;
  int done_cnt = 0;
  int exp_done = 0;
  int ar_cnt = 0;
  int occ_in = 0;
  int occ_out = 0;
  logic [31:0] salt;
  bit err_inject = 1'b0;

  logic [31:0] exp_ar_addr_q[$];
  logic [7:0]  exp_ar_len_q[$];
  logic [DW-1:0] exp_data_q[$];
  logic [31:0] sl_addr_q[$];
  logic [7:0]  sl_len_q[$];
  bit          sl_err_q[$];

  task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string nm, input logic [DW-1:0] act);
    tests++;
    fails++;
    $display("FAIL %s: got %0h with nothing expected (t=%0t)", nm, act, $time);
  endtask

  function automatic logic [DW-1:0] data_of(input logic [31:0] a);
    logic [DW-1:0] d;
    for (int k = 0; k < DW / 32; k++) d[k*32 +: 32] = a ^ salt ^ (32'h0101_0101 * 32'(k));
    return d;
  endfunction

  // Reference: walk the command, cutting bursts at MB beats and 4 KB pages.
  task automatic push_expect(input logic [31:0] addr, input int beats);
    logic [31:0] a;
    int r, page, len;
    a = addr & ~32'd31;
    r = beats;
    while (r > 0) begin
      page = (4096 - int'(a[11:0])) / 32;
      len  = r;
      if (len > MB)   len = MB;
      if (len > page) len = page;
      exp_ar_addr_q.push_back(a);
      exp_ar_len_q.push_back(8'(len - 1));
      for (int i = 0; i < len; i++) exp_data_q.push_back(data_of(a + 32'(i * 32)));
      a = a + 32'(len * 32);
      r = r - len;
    end
    exp_done++;
  endtask

  task automatic issue(input logic [31:0] a, input int n);
    bit ok;
    ok = 1'b0;
    @(posedge clk); #1;
    cmd_valid = 1'b1;
    cmd_addr  = a;
    cmd_beats = LW'(n);
    for (int i = 0; i < 2000 && !ok; i++) begin
      @(negedge clk);
      if (cmd_ready) ok = 1'b1;
    end
    chk("cmd_accept", ok, 1'b1);
    if (ok) push_expect(a, n);
    @(posedge clk); #1;
    cmd_valid = 1'b0;
  endtask

  task automatic wait_done(input bit always_ready);
    bit fin;
    fin = 1'b0;
    for (int i = 0; i < 4000 && !fin; i++) begin
      @(posedge clk); #1;
      out_ready = always_ready ? 1'b1 : ($urandom % 4 != 0);
      fin = (done_cnt == exp_done) && (exp_data_q.size() == 0);
    end
    chk("done_count", done_cnt, exp_done);
    chk("data_drained", exp_data_q.size(), 0);
    chk("ar_all_issued", exp_ar_addr_q.size(), 0);
  endtask

  // AR slave: random ready
  initial begin
    arready = 1'b0;
    forever begin
      @(posedge clk); #1;
      arready = rst ? 1'b0 : ($urandom % 3 != 0);
    end
  end

  // R slave: returns bursts in order with random gaps and optional faults
  initial begin
    logic [31:0] r_addr;
    int  r_len, r_idx;
    bit  r_err, r_act, acc;
    r_act = 1'b0; r_addr = '0; r_len = 0; r_idx = 0; r_err = 1'b0;
    rvalid = 1'b0; rdata = '0; rresp = 2'b00; rlast = 1'b0;
    forever begin
      @(negedge clk);
      acc = rvalid && rready;
      @(posedge clk); #1;
      if (rst) begin
        r_act = 1'b0;
        sl_addr_q.delete(); sl_len_q.delete(); sl_err_q.delete();
        rvalid = 1'b0;
      end else begin
        if (acc && r_act) begin
          r_idx++;
          if (r_idx > r_len) r_act = 1'b0;
        end
        if (!r_act && sl_addr_q.size() > 0) begin
          r_addr = sl_addr_q.pop_front();
          r_len  = int'(sl_len_q.pop_front());
          r_err  = sl_err_q.pop_front();
          r_idx  = 0;
          r_act  = 1'b1;
        end
        if (r_act && ($urandom % 4 != 0)) begin
          rvalid = 1'b1;
          rdata  = data_of(r_addr + 32'(r_idx * 32));
          rresp  = (r_err && r_idx == 4) ? 2'b10 : 2'b00;
          rlast  = (r_err && r_idx == 8) || (r_idx == r_len);
        end else begin
          rvalid = 1'b0;
        end
      end
    end
  end

  // Monitor: AR checks, credit, output scoreboard, done counting
  initial begin
    bit          ar_pend;
    logic [31:0] pend_addr;
    logic [7:0]  pend_len;
    logic [DW-1:0] exp_d;
    ar_pend = 1'b0; pend_addr = '0; pend_len = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        occ_in = 0; occ_out = 0; ar_pend = 1'b0;
      end else begin
        if (ar_pend) begin
          chk("ar_hold_valid", arvalid, 1'b1);
          chk("ar_hold_addr", araddr, pend_addr);
          chk("ar_hold_len", arlen, pend_len);
        end
        if (arvalid) begin
          chk("ar_credit", (FD - (occ_in - occ_out)) >= (int'(arlen) + 1), 1'b1);
          chk("ar_fixed", {arid, arsize, arburst}, {4'd0, 3'd5, 2'b01});
          if (arready) begin
            ar_cnt++;
            ar_pend = 1'b0;
            if (exp_ar_addr_q.size() == 0) fail_now("ar_unexpected", araddr);
            else begin
              chk("ar_addr", araddr, exp_ar_addr_q.pop_front());
              chk("ar_len", arlen, exp_ar_len_q.pop_front());
            end
            sl_addr_q.push_back(araddr);
            sl_len_q.push_back(arlen);
            sl_err_q.push_back(err_inject);
          end else begin
            ar_pend = 1'b1; pend_addr = araddr; pend_len = arlen;
          end
        end else begin
          ar_pend = 1'b0;
        end
        if (rvalid && rready) occ_in++;
        if (out_valid && out_ready) begin
          occ_out++;
          if (exp_data_q.size() == 0) fail_now("out_unexpected", out_data);
          else begin
            exp_d = exp_data_q.pop_front();
            chk("out_data", out_data, exp_d);
          end
        end
        if (done) done_cnt++;
      end
    end
  end

  initial begin
    int base;
    bit seen;
    logic [31:0] ra;
    int rn;
    cmd_valid = 1'b0; cmd_addr = '0; cmd_beats = '0; out_ready = 1'b0;
    salt = $urandom;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_outputs", {arvalid, rready, out_valid, busy, done, error, cmd_ready}, 7'b0);
    @(posedge clk); #2 rst = 1'b0;
    @(negedge clk);
    chk("rst_release_cmd_ready", cmd_ready, 1'b1);

    // Straight 40-beat read, three bursts
    base = ar_cnt;
    out_ready = 1'b1;
    issue(32'h1000, 40);
    wait_done(1'b1);
    chk("t1_ar_count", ar_cnt - base, 3);
    chk("t1_error", error, 1'b0);

    // 4 KB page crossing
    base = ar_cnt;
    issue(32'h0F80, 16);
    wait_done(1'b0);
    chk("t2_ar_count", ar_cnt - base, 2);

    // Credit backpressure
    base = ar_cnt;
    out_ready = 1'b0;
    issue(32'h0, 100);
    repeat (300) @(posedge clk);
    @(negedge clk);
    chk("bp_ar_count", ar_cnt - base, 4);
    chk("bp_arvalid_low", arvalid, 1'b0);
    chk("bp_fill", occ_in - occ_out, 64);
    @(posedge clk); #1;
    out_ready = 1'b1;
    repeat (15) @(posedge clk);
    @(negedge clk);
    chk("bp_arvalid_15pops", arvalid, 1'b0);
    @(posedge clk); #1;
    out_ready = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      if (arvalid) seen = 1'b1;
    end
    chk("bp_arvalid_rise", seen, 1'b1);
    wait_done(1'b0);
    chk("bp_ar_total", ar_cnt - base, 7);

    // Zero-length command
    base = ar_cnt;
    issue(32'h40, 0);
    @(negedge clk);
    chk("z_t1", {done, arvalid, cmd_ready}, 3'b000);
    @(negedge clk);
    chk("z_t2_done", {done, arvalid, cmd_ready}, 3'b100);
    @(negedge clk);
    chk("z_t3_ready", {done, arvalid, cmd_ready}, 3'b001);
    wait_done(1'b0);
    chk("z_ar_count", ar_cnt - base, 0);

    // Bad RRESP and early RLAST
    err_inject = 1'b1;
    issue(32'h3000, 16);
    wait_done(1'b0);
    err_inject = 1'b0;
    chk("err_set", error, 1'b1);
    issue(32'h3400, 8);
    @(negedge clk);
    chk("err_clear_on_accept", error, 1'b0);
    wait_done(1'b0);
    chk("err_stays_clear", error, 1'b0);

    // Reset in the middle of a burst
    out_ready = 1'b0;
    issue(32'h5000, 16);
    seen = 1'b0;
    for (int i = 0; i < 500 && !seen; i++) begin
      @(negedge clk);
      if (occ_in - occ_out >= 10) seen = 1'b1;
    end
    chk("rst_fill_reached", seen, 1'b1);
    @(posedge clk); #2 rst = 1'b1;
    @(negedge clk);
    chk("rst_mid_outputs", {arvalid, rready, out_valid, busy, done, error, cmd_ready}, 7'b0);
    exp_ar_addr_q.delete(); exp_ar_len_q.delete(); exp_data_q.delete();
    exp_done = done_cnt;
    repeat (2) @(posedge clk);
    #2 rst = 1'b0;
    @(negedge clk);
    chk("rst_mid_release", {busy, out_valid, cmd_ready}, 3'b001);
    issue(32'h2000, 4);
    wait_done(1'b1);
    chk("rst_after_error", error, 1'b0);

    // Address wrap at the top of the space
    issue(32'hFFFF_FFC0, 8);
    wait_done(1'b0);

    // Random commands
    for (int t = 0; t < 12; t++) begin
      ra = $urandom;
      if (t % 3 == 0) ra[11:0] = 12'hF00 | 12'($urandom_range(0, 255));
      rn = $urandom_range(0, 60);
      issue(ra, rn);
      wait_done(1'b0);
      chk("rand_error", error, 1'b0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
